// File: rtl/tracer_pkg.sv
// Shared types and constants for the tracer nibble-serial command sequencer.
package tracer_pkg;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   localparam int          NIBBLES_PER_CMD = 4;
   localparam logic [7:0]  TIMEOUT_RESULT  = 8'hFF;

endpackage

// File: rtl/nibble_loader.sv
// Assembles two operand bytes from four nibble transfers into a staging pair.
module nibble_loader
   import tracer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_en,
   input  logic       i_strobe,
   input  logic [3:0] i_data,
   output logic [7:0] stage_a_next,
   output logic [7:0] stage_b_next,
   output logic       last
);

   logic [1:0] nc_q, nc_d;
   logic [7:0] stage_a_q, stage_a_d;
   logic [7:0] stage_b_q, stage_b_d;
   logic       accept;

   assign accept = load_en & i_strobe;

   always_comb begin
      nc_d      = nc_q;
      stage_a_d = stage_a_q;
      stage_b_d = stage_b_q;
      if (accept) begin
         case (nc_q)
            2'd0:    stage_a_d[7:4] = i_data;
            2'd1:    stage_a_d[3:0] = i_data;
            2'd2:    stage_b_d[7:4] = i_data;
            default: stage_b_d[3:0] = i_data;
         endcase
         nc_d = nc_q + 2'd1;
      end
   end

   // The final nibble is exposed combinationally so the top can latch full bytes on the same edge.
   assign stage_a_next = stage_a_d;
   assign stage_b_next = stage_b_d;
   assign last         = accept && (nc_q == 2'(NIBBLES_PER_CMD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         nc_q      <= 2'd0;
         stage_a_q <= 8'h00;
         stage_b_q <= 8'h00;
      end else begin
         nc_q      <= nc_d;
         stage_a_q <= stage_a_d;
         stage_b_q <= stage_b_d;
      end
   end

endmodule

// File: rtl/tracer_seq.sv
// Command sequencer: loads operands, starts the core, waits for done with a
// bounded timeout and holds the result on the output pins.
module tracer_seq
   import tracer_pkg::*;
#(
   parameter int TIMEOUT = 15
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_strobe,
   input  logic [3:0] i_data,
   input  logic       abs,
   output logic       core_start,
   output logic [7:0] core_op_a,
   output logic [7:0] core_op_b,
   output logic       core_abs,
   input  logic       core_done,
   input  logic [7:0] core_result,
   output logic [7:0] result,
   output logic       busy,
   output logic       err
);

   localparam int              TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    op_a_q, op_a_d;
   logic [7:0]    op_b_q, op_b_d;
   logic          abs_q, abs_d;
   logic [7:0]    result_q, result_d;
   logic          err_q, err_d;

   logic [7:0]    stage_a_next, stage_b_next;
   logic          last;

   nibble_loader u_loader (
      .clk          (clk),
      .reset        (reset),
      .load_en      (state_q == S_LOAD),
      .i_strobe     (i_strobe),
      .i_data       (i_data),
      .stage_a_next (stage_a_next),
      .stage_b_next (stage_b_next),
      .last         (last)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      abs_d    = abs_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         S_LOAD: begin
            if (last) begin
               op_a_d  = stage_a_next;
               op_b_d  = stage_b_next;
               abs_d   = abs;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // A done arriving on the last permitted cycle still counts as success.
            if (core_done) begin
               result_d = core_result;
               err_d    = 1'b0;
               state_d  = S_LOAD;
            end else if (timer_q == TIMER_LAST) begin
               result_d = TIMEOUT_RESULT;
               err_d    = 1'b1;
               state_d  = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_LOAD;
         timer_q  <= '0;
         op_a_q   <= 8'h00;
         op_b_q   <= 8'h00;
         abs_q    <= 1'b0;
         result_q <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         abs_q    <= abs_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign core_start = (state_q == S_ISSUE);
   assign busy       = (state_q != S_LOAD);
   assign core_op_a  = op_a_q;
   assign core_op_b  = op_b_q;
   assign core_abs   = abs_q;
   assign result     = result_q;
   assign err        = err_q;

endmodule

// File: tb/tb_tracer_seq.sv
// Randomized scoreboard bench for tracer_seq: a driver pushes the expected
// command outcome, a monitor checks it when start and busy-fall are seen.
module tb_tracer_seq;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_strobe;
   logic [3:0] i_data;
   logic       abs_in;
   logic       core_start;
   logic [7:0] core_op_a;
   logic [7:0] core_op_b;
   logic       core_abs;
   logic       core_done;
   logic [7:0] core_result;
   logic [7:0] result;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ab;
      logic [7:0] res;
      logic       er;
      int         busy_len;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] hold_res;
   logic       hold_err;
   logic       prev_start;
   logic       prev_busy;
   int         busy_cnt;

   tracer_seq #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_strobe    (i_strobe),
      .i_data      (i_data),
      .abs         (abs_in),
      .core_start  (core_start),
      .core_op_a   (core_op_a),
      .core_op_b   (core_op_b),
      .core_abs    (core_abs),
      .core_done   (core_done),
      .core_result (core_result),
      .result      (result),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one full command and play the core: k is the WAIT cycle index at
   // which done is raised; k >= TIMEOUT means the core never answers.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ab,
                                input int k, input logic [7:0] res, input bit noise, input bit junk);
      logic [3:0] nib [4];
      exp_t e;
      nib[0] = a[7:4];
      nib[1] = a[3:0];
      nib[2] = b[7:4];
      nib[3] = b[3:0];
      e.a  = a;
      e.b  = b;
      e.ab = ab;
      if (k < TIMEOUT) begin
         e.res      = res;
         e.er       = 1'b0;
         e.busy_len = k + 2;
      end else begin
         e.res      = 8'hFF;
         e.er       = 1'b1;
         e.busy_len = TIMEOUT + 1;
      end
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         int gaps;
         gaps = noise ? int'($urandom_range(0, 2)) : 0;
         repeat (gaps) begin
            i_strobe    = 1'b0;
            i_data      = 4'($urandom);
            abs_in      = 1'($urandom);
            core_done   = 1'($urandom);
            core_result = 8'($urandom);
            @(negedge clk);
         end
         i_strobe  = 1'b1;
         i_data    = nib[i];
         abs_in    = (i == 3) ? ab : 1'($urandom);
         core_done = noise ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      // ISSUE cycle: strobes and done are both meant to be ignored here
      i_strobe    = junk ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      i_data      = 4'hF;
      core_done   = noise ? 1'($urandom) : 1'b0;
      core_result = 8'($urandom);
      @(negedge clk);
      if (k < TIMEOUT) begin
         repeat (k) begin
            core_done = 1'b0;
            i_strobe  = junk ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            i_data    = junk ? 4'hF : 4'($urandom);
            @(negedge clk);
         end
         core_done   = 1'b1;
         core_result = res;
         i_strobe    = junk ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
         @(negedge clk);
      end else begin
         repeat (TIMEOUT) begin
            core_done = 1'b0;
            i_strobe  = junk ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            i_data    = junk ? 4'hF : 4'($urandom);
            @(negedge clk);
         end
      end
      core_done = 1'b0;
      i_strobe  = 1'b0;
      checkOutput("busy_after_cmd", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: operands at each start pulse, outcome at each busy fall,
   // and result/err must otherwise hold their last value.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         hold_res   = 8'h00;
         hold_err   = 1'b0;
         prev_start = 1'b0;
         prev_busy  = 1'b0;
         busy_cnt   = 0;
      end else begin
         if (core_start) begin
            checkOutput("start_single", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
               checkOutput("start_unexpected", 32'd1, 32'd0);
            end else begin
               checkOutput("core_op_a", {24'd0, core_op_a}, {24'd0, exp_q[0].a});
               checkOutput("core_op_b", {24'd0, core_op_b}, {24'd0, exp_q[0].b});
               checkOutput("core_abs",  {31'd0, core_abs},  {31'd0, exp_q[0].ab});
            end
         end
         if (busy) busy_cnt++;
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               checkOutput("done_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("result",   {24'd0, result}, {24'd0, e.res});
               checkOutput("err",      {31'd0, err},    {31'd0, e.er});
               checkOutput("busy_len", busy_cnt,        e.busy_len);
               hold_res = e.res;
               hold_err = e.er;
            end
            busy_cnt = 0;
         end else begin
            checkOutput("result_hold", {24'd0, result}, {24'd0, hold_res});
            checkOutput("err_hold",    {31'd0, err},    {31'd0, hold_err});
         end
         prev_start = core_start;
         prev_busy  = busy;
      end
   end

   initial begin
      reset       = 1'b1;
      i_strobe    = 1'b0;
      i_data      = 4'h0;
      abs_in      = 1'b0;
      core_done   = 1'b0;
      core_result = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      checkOutput("rst_op_a",  {24'd0, core_op_a}, 32'd0);
      checkOutput("rst_op_b",  {24'd0, core_op_b}, 32'd0);
      checkOutput("rst_abs",   {31'd0, core_abs},  32'd0);
      checkOutput("rst_start", {31'd0, core_start}, 32'd0);
      checkOutput("rst_busy",  {31'd0, busy},      32'd0);
      checkOutput("rst_err",   {31'd0, err},       32'd0);
      checkOutput("rst_res",   {24'd0, result},    32'd0);

      applyStimulus(8'h3C, 8'h5A, 1'b1, 2, 8'h7E, 1'b0, 1'b0);
      applyStimulus(8'h12, 8'h34, 1'b0, TIMEOUT, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'hA5, 8'h0F, 1'b1, TIMEOUT - 1, 8'hC3, 1'b0, 1'b0);
      applyStimulus(8'h81, 8'h7F, 1'b0, 5, 8'h55, 1'b0, 1'b1);
      applyStimulus(8'h96, 8'h69, 1'b1, 0, 8'h00, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(8'($urandom), 8'($urandom), 1'($urandom),
                       int'($urandom_range(0, TIMEOUT + 2)), 8'($urandom), 1'b1, 1'b0);
      end

      // Reset after a partial command must discard it and clear outputs.
      applyStimulus(8'hE7, 8'h18, 1'b1, 1, 8'h42, 1'b0, 1'b0);
      i_strobe = 1'b1;
      i_data   = 4'h9;
      @(negedge clk);
      i_data   = 4'h6;
      @(negedge clk);
      i_strobe = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      checkOutput("mid_rst_op_a", {24'd0, core_op_a}, 32'd0);
      checkOutput("mid_rst_op_b", {24'd0, core_op_b}, 32'd0);
      checkOutput("mid_rst_abs",  {31'd0, core_abs},  32'd0);
      checkOutput("mid_rst_res",  {24'd0, result},    32'd0);
      checkOutput("mid_rst_busy", {31'd0, busy},      32'd0);
      applyStimulus(8'hD2, 8'h4B, 1'b0, 3, 8'h99, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tracer_seq.md
# tracer_seq

Nibble-serial command sequencer sitting between the 4-bit chip input pins and the tracer compute core. Assembles two 8-bit operands from four 4-bit transfers, latches the `abs` mode bit, and issues a one-cycle start to the core. Waits for the core's done with a bounded timeout, then holds the 8-bit result on the output pins until the next command completes. This makes the core usable through the 8-in / 8-out pin budget.

## Interface

- Clock is `clk`. Reset is `reset`: synchronous, active-high, single clock domain.

**Parameters**
- `TIMEOUT`, default 15: maximum number of cycles spent in WAIT before aborting. Legal range 1..255.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `i_strobe` in 1: nibble-valid. Sampled every cycle; each high cycle is one transfer.
- `i_data` in 4: nibble payload, valid when `i_strobe` is high.
- `abs` in 1: mode bit. Captured on the cycle the 4th nibble is accepted.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_op_a` out 8: operand A, stable from ISSUE until the next command's 4th nibble.
- `core_op_b` out 8: operand B, same stability as `core_op_a`.
- `core_abs` out 1: latched mode bit.
- `core_done` in 1: core completion. Sampled only in WAIT.
- `core_result` in 8: core result, valid when `core_done` is high.
- `result` out 8: registered result driven to the output pins.
- `busy` out 1: high in ISSUE and WAIT.
- `err` out 1: high if the last command timed out.

## Operation

- States: LOAD, ISSUE, WAIT. Encoding lives in the package.
- **LOAD**
  - A 2-bit nibble counter `nc` advances on each cycle with `i_strobe` high.
  - Nibble order: `nc=0` → A[7:4], `nc=1` → A[3:0], `nc=2` → B[7:4], `nc=3` → B[3:0].
  - Operand registers shift in place: bytes are written nibble-by-nibble into a staging pair, not the live `core_op_*`.
  - On accepting `nc=3`:
    - staging copies to `core_op_a` / `core_op_b`;
    - `abs` is latched to `core_abs`;
    - `nc` wraps to 0;
    - next state is ISSUE.
- **ISSUE**
  - `core_start` is high for exactly this one cycle, decoded from the state register.
  - Wait timer clears to 0. Next state is WAIT.
- **WAIT**
  - Timer increments each cycle.
  - If `core_done` is high: `result`←`core_result`, `err`←0, go to LOAD.
  - Otherwise, if timer == `TIMEOUT`−1: `result`←8'hFF, `err`←1, go to LOAD.
  - `core_done` and timeout in the same cycle: done wins.
- `i_strobe` during ISSUE/WAIT is ignored. It does not advance `nc` and does not update staging.
- `core_done` outside WAIT is ignored.
- A partial command (`nc` ≠ 0) persists indefinitely in LOAD. There is no inter-nibble timeout.
- `result` and `err` change only on WAIT exit. They hold across subsequent loads.

## Timing

- Reset values:
  - state is LOAD, `nc` 0, timer 0;
  - staging, `core_op_a`, `core_op_b`, `result` all 8'h00;
  - `core_abs` 0, `core_start` 0, `busy` 0, `err` 0.
- Reset mid-command discards the partial nibbles and any in-flight core transaction. The first strobe after reset is A[7:4].
- Edge E accepts the 4th nibble. `core_start` and `busy` are high in the cycle after E. WAIT begins at E+2.
- `core_done` sampled at edge D → `result` / `err` visible after D. LOAD resumes in that same cycle, so a new nibble can be accepted at D+1.
- Timeout path: WAIT occupies exactly `TIMEOUT` cycles. Minimum command turnaround is 4 strobe cycles + 1 ISSUE + 1 WAIT.
- Timer width is $clog2(`TIMEOUT`+1) bits. It never wraps, because it exits at `TIMEOUT`−1.

## Structure

- Package `tracer_pkg`:
  - state enum (LOAD / ISSUE / WAIT);
  - `NIBBLES_PER_CMD` = 4;
  - `TIMEOUT_RESULT` = 8'hFF.
- Sub-module `nibble_loader`: owns `nc`, the staging registers, and the `last` flag (asserted when accepting `nc=3`).
- The FSM, timer and result registers stay in `tracer_seq`.

## Test plan

- Reset, then strobe nibbles 3, C, 5, A with `abs`=1 on the 4th → `core_op_a`=8'h3C, `core_op_b`=8'h5A, `core_abs`=1. `core_start` is a single-cycle pulse the cycle after the 4th strobe.
- Core model asserts `core_done` 3 cycles into WAIT with `core_result`=8'h7E → `result`=8'h7E, `err`=0, `busy` drops the same cycle.
- No `core_done` with `TIMEOUT`=15 → exactly 15 WAIT cycles, then `result`=8'hFF, `err`=1. The next successful command clears `err`.
- `core_done` asserted on the final WAIT cycle (timer=14) → done wins: `result`=`core_result`, `err`=0.
- Strobes with `i_data`=F during WAIT → ignored; the next command's first nibble still lands in A[7:4]. Also: `reset` after 2 nibbles → `nc`=0, operands and `result` back to 8'h00.
